// File: rtl/vram_arbiter.sv
// Screen-RAM arbiter: video cell fetches take priority over Z80 accesses.
// Optional wait-cycle counter: define VRAM_ARB_WAIT_CNT_EN.
module vram_arbiter #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_pix_addr,
    input  logic [ADDR_W-1:0] vid_attr_addr,
    output logic [7:0]        vid_pix_data,
    output logic [7:0]        vid_attr_data,
    output logic              vid_valid,
    output logic              vid_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              n_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
`ifdef VRAM_ARB_WAIT_CNT_EN
    ,
    input  logic              wait_clr,
    output logic [15:0]       wait_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        VID_PIX,
        VID_ATTR,
        VID_END,
        CPU_ACC,
        CPU_END
    } state_t;

    state_t            state;
    logic              pend;
    logic [ADDR_W-1:0] pend_pix;
    logic [ADDR_W-1:0] pend_attr;
    logic [ADDR_W-1:0] cur_pix;
    logic [ADDR_W-1:0] cur_attr;
    logic              arb;
    logic              take_vid;
    logic              take_cpu;

    assign n_wait   = !(cpu_req && !cpu_ack);
    assign arb      = (state == IDLE) || (state == VID_END) || (state == CPU_END);
    assign take_vid = arb && (vid_req || pend);
    assign take_cpu = arb && !take_vid && (state != CPU_END)
                      && cpu_req && !cpu_ack;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        case (state)
            VID_PIX:  ram_addr = cur_pix;
            VID_ATTR: ram_addr = cur_attr;
            CPU_ACC: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state         <= IDLE;
            pend          <= 1'b0;
            pend_pix      <= '0;
            pend_attr     <= '0;
            cur_pix       <= '0;
            cur_attr      <= '0;
            vid_pix_data  <= 8'h00;
            vid_attr_data <= 8'h00;
            vid_valid     <= 1'b0;
            vid_overrun   <= 1'b0;
            cpu_rdata     <= 8'h00;
            cpu_ack       <= 1'b0;
        end else begin
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;

            unique case (state)
                VID_PIX:  state <= VID_ATTR;
                VID_ATTR: begin
                    state        <= VID_END;
                    vid_pix_data <= ram_rdata;
                end
                CPU_ACC:  state <= CPU_END;
                default: begin
                    if (take_vid)
                        state <= VID_PIX;
                    else if (take_cpu)
                        state <= CPU_ACC;
                    else
                        state <= IDLE;
                end
            endcase

            if (state == VID_END) begin
                vid_attr_data <= ram_rdata;
                vid_valid     <= 1'b1;
            end
            if (state == CPU_END) begin
                cpu_rdata <= ram_rdata;
                cpu_ack   <= 1'b1;
            end

            // A request arriving as the slot is consumed refills it, not an overrun.
            if (vid_req) begin
                pend_pix  <= vid_pix_addr;
                pend_attr <= vid_attr_addr;
            end
            if (take_vid) begin
                cur_pix  <= pend ? pend_pix : vid_pix_addr;
                cur_attr <= pend ? pend_attr : vid_attr_addr;
                pend     <= pend && vid_req;
            end else if (vid_req) begin
                pend <= 1'b1;
                if (pend)
                    vid_overrun <= 1'b1;
            end
        end
    end

`ifdef VRAM_ARB_WAIT_CNT_EN
    logic [15:0] wait_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            wait_cnt <= 16'h0000;
        else if (wait_clr)
            wait_cnt <= 16'h0000;
        else if (!n_wait && wait_cnt != 16'hFFFF)
            wait_cnt <= wait_cnt + 16'h0001;
    end

    assign wait_cycles = wait_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: bench-side RAM, per-cycle reference model, directed cases.
// Counter checks are built when VRAM_ARB_WAIT_CNT_EN is defined.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        vid_req = 1'b0;
    logic [12:0] vid_pix_addr = '0;
    logic [12:0] vid_attr_addr = '0;
    logic [7:0]  vid_pix_data;
    logic [7:0]  vid_attr_data;
    logic        vid_valid;
    logic        vid_overrun;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        n_wait;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
`ifdef VRAM_ARB_WAIT_CNT_EN
    logic        wait_clr = 1'b0;
    logic [15:0] wait_cycles;
`endif

    int n_chk = 0;
    int n_fail = 0;

    vram_arbiter #(.ADDR_W(13)) dut (
        .clk(clk), .n_reset(n_reset),
        .vid_req(vid_req), .vid_pix_addr(vid_pix_addr),
        .vid_attr_addr(vid_attr_addr), .vid_pix_data(vid_pix_data),
        .vid_attr_data(vid_attr_data), .vid_valid(vid_valid),
        .vid_overrun(vid_overrun), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .n_wait(n_wait), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
`ifdef VRAM_ARB_WAIT_CNT_EN
        , .wait_clr(wait_clr), .wait_cycles(wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous read-first RAM with a preload port.
    logic [7:0]  mem [0:8191];
    logic        ld_en = 1'b0;
    logic [12:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one operation in flight, tracked as kind + phase.
    int          op = 0;
    int          ph = 0;
    logic        pend = 1'b0;
    logic [12:0] pp = '0, pa = '0, cp = '0, ca = '0;
    logic [7:0]  e_pix = '0, e_attr = '0, e_rd = '0, t_a = '0, t_b = '0;
    logic        e_valid = 1'b0, e_ack = 1'b0, e_ovr = 1'b0;
    logic [15:0] e_wc = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                op = 0; ph = 0; pend = 1'b0;
                e_pix = '0; e_attr = '0; e_rd = '0;
                e_valid = 1'b0; e_ack = 1'b0; e_ovr = 1'b0; e_wc = '0;
                chk("rst_vid_valid", vid_valid, 0);
                chk("rst_cpu_ack", cpu_ack, 0);
                chk("rst_overrun", vid_overrun, 0);
                chk("rst_ram_we", ram_we, 0);
                chk("rst_ram_addr", ram_addr, 0);
                chk("rst_pix", vid_pix_data, 0);
                chk("rst_attr", vid_attr_data, 0);
                chk("rst_rdata", cpu_rdata, 0);
                chk("rst_n_wait", n_wait, !cpu_req);
`ifdef VRAM_ARB_WAIT_CNT_EN
                chk("rst_wait_cycles", wait_cycles, 0);
`endif
            end else begin
                logic [12:0] x_addr;
                logic        x_we, x_nw, nv, na, arb;
                x_addr = '0;
                x_we   = 1'b0;
                if (op == 1 && ph == 0) x_addr = cp;
                if (op == 1 && ph == 1) x_addr = ca;
                if (op == 2 && ph == 0) begin
                    x_addr = cpu_addr;
                    x_we   = cpu_we;
                end
                x_nw = !(cpu_req && !e_ack);
                chk("ram_addr", ram_addr, x_addr);
                chk("ram_we", ram_we, x_we);
                if (x_we) chk("ram_wdata", ram_wdata, cpu_wdata);
                chk("n_wait", n_wait, x_nw);
                chk("vid_valid", vid_valid, e_valid);
                chk("vid_pix_data", vid_pix_data, e_pix);
                chk("vid_attr_data", vid_attr_data, e_attr);
                chk("vid_overrun", vid_overrun, e_ovr);
                chk("cpu_ack", cpu_ack, e_ack);
                chk("cpu_rdata", cpu_rdata, e_rd);
`ifdef VRAM_ARB_WAIT_CNT_EN
                chk("wait_cycles", wait_cycles, e_wc);
                if (wait_clr) e_wc = '0;
                else if (!x_nw && e_wc != 16'hFFFF) e_wc = e_wc + 1;
`endif
                nv = 1'b0;
                na = 1'b0;
                if (op == 1 && ph == 0) t_a = mem[cp];
                if (op == 1 && ph == 1) begin e_pix = t_a; t_b = mem[ca]; end
                if (op == 1 && ph == 2) begin e_attr = t_b; nv = 1'b1; end
                if (op == 2 && ph == 0) t_a = mem[cpu_addr];
                if (op == 2 && ph == 1) begin e_rd = t_a; na = 1'b1; end
                arb = (op == 0) || (op == 1 && ph == 2) || (op == 2 && ph == 1);
                if (arb && (vid_req || pend)) begin
                    if (pend) begin cp = pp; ca = pa; end
                    else begin cp = vid_pix_addr; ca = vid_attr_addr; end
                    pend = pend && vid_req;
                    if (vid_req) begin pp = vid_pix_addr; pa = vid_attr_addr; end
                    op = 1; ph = 0;
                end else if (arb && op != 2 && cpu_req && !e_ack) begin
                    op = 2; ph = 0;
                end else if (arb) begin
                    op = 0; ph = 0;
                end else begin
                    ph++;
                    if (vid_req) begin
                        if (pend) e_ovr = 1'b1;
                        pend = 1'b1;
                        pp = vid_pix_addr;
                        pa = vid_attr_addr;
                    end
                end
                e_valid = nv;
                e_ack = na;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [12:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic access(input bit vid, input logic [12:0] pa_i,
                          input logic [12:0] aa_i, input bit we,
                          input logic [12:0] a, input logic [7:0] wd,
                          output int lat, output int nw, output int vt,
                          output int wen, output logic [7:0] rd);
        lat = 0; nw = 0; vt = 0; wen = 0; rd = 8'h00;
        vid_req = vid; vid_pix_addr = pa_i; vid_attr_addr = aa_i;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (!n_wait) nw++;
            if (ram_we) wen++;
            tick();
            lat++;
            vid_req = 1'b0;
            if (vid_valid && vt == 0) vt = lat;
            if (cpu_ack) begin
                rd = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        tick();
    endtask

    int lat, nw, vt, wen, cnt, sum;
    logic [7:0] rd, p1, a1, p2, a2;

    initial begin
        load(13'h1800, 8'h47);
        load(13'h0000, 8'h5A);
        load(13'h0020, 8'h3C);
        load(13'h1801, 8'h38);
        load(13'h0100, 8'h11);
        load(13'h1900, 8'h21);
        load(13'h0101, 8'h12);
        load(13'h1901, 8'h22);
        load(13'h0102, 8'h13);
        load(13'h1902, 8'h23);
        load(13'h0300, 8'h00);
        n_reset = 1'b1;
        tick();

        access(0, 13'h0, 13'h0, 0, 13'h1800, 8'h00, lat, nw, vt, wen, rd);
        chk("rd1800_lat", lat, 3);
        chk("rd1800_data", rd, 8'h47);
        chk("rd1800_nwait_low", nw, 3);

        access(0, 13'h0, 13'h0, 1, 13'h0000, 8'hAA, lat, nw, vt, wen, rd);
        chk("wr0_we_cycles", wen, 1);
        chk("wr0_lat", lat, 3);
        chk("wr0_old_byte", rd, 8'h5A);
        access(0, 13'h0, 13'h0, 0, 13'h0000, 8'h00, lat, nw, vt, wen, rd);
        chk("rd0_data", rd, 8'hAA);

        access(1, 13'h0020, 13'h1801, 0, 13'h0000, 8'h00, lat, nw, vt, wen, rd);
        chk("contend_vid_t", vt, 4);
        chk("contend_ack_t", lat, 6);
        chk("contend_pix", vid_pix_data, 8'h3C);
        chk("contend_attr", vid_attr_data, 8'h38);
        chk("contend_rd", rd, 8'hAA);
        chk("contend_nwait_low", nw, 6);

        vid_req = 1'b1; vid_pix_addr = 13'h0100; vid_attr_addr = 13'h1900;
        tick();
        vid_pix_addr = 13'h0101; vid_attr_addr = 13'h1901;
        tick();
        vid_pix_addr = 13'h0102; vid_attr_addr = 13'h1902;
        tick();
        vid_req = 1'b0;
        cnt = 0; p1 = '0; a1 = '0; p2 = '0; a2 = '0;
        for (int i = 0; i < 12; i++) begin
            if (vid_valid) begin
                cnt++;
                if (cnt == 1) begin p1 = vid_pix_data; a1 = vid_attr_data; end
                else begin p2 = vid_pix_data; a2 = vid_attr_data; end
            end
            tick();
        end
        chk("burst_fetches", cnt, 2);
        chk("burst_pix1", p1, 8'h11);
        chk("burst_attr1", a1, 8'h21);
        chk("burst_pix2", p2, 8'h13);
        chk("burst_attr2", a2, 8'h23);
        chk("burst_overrun", vid_overrun, 1);

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0300; cpu_wdata = 8'h55;
        tick();
        chk("abort_we_before", ram_we, 1);
        #1 n_reset = 1'b0;
        #1;
        chk("abort_we_drop", ram_we, 0);
        chk("abort_addr_zero", ram_addr, 0);
        chk("abort_no_ack", cpu_ack, 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        chk("abort_no_ack2", cpu_ack, 0);
        n_reset = 1'b1;
        tick();
        chk("abort_no_ack3", cpu_ack, 0);
        chk("abort_overrun_clr", vid_overrun, 0);
        access(0, 13'h0, 13'h0, 0, 13'h1800, 8'h00, lat, nw, vt, wen, rd);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", rd, 8'h47);

`ifdef VRAM_ARB_WAIT_CNT_EN
        wait_clr = 1'b1;
        tick();
        wait_clr = 1'b0;
        chk("wc_clear0", wait_cycles, 0);
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            access(1, 13'h0020, 13'h1801, 0, 13'h1800, 8'h00, lat, nw, vt, wen, rd);
            sum += nw;
        end
        chk("wc_sum_lit", sum, 60);
        chk("wc_total", wait_cycles, sum);
        wait_clr = 1'b1;
        tick();
        wait_clr = 1'b0;
        chk("wc_clear1", wait_cycles, 0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
